// File: rtl/i2c_byte_tx.sv
// Write-only I2C master: START, {ADDR,W}, ACK, data byte, ACK, STOP.
// Drives open-drain SCL/SDA from registered outputs, quarter-bit timed.
module i2c_byte_tx #(
  parameter int         CLK_HZ = 100_000_000,
  parameter int         SCL_HZ = 100_000,
  parameter logic [6:0] ADDR   = 7'h27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam int         Q         = CLK_HZ / (4 * SCL_HZ);
  localparam int         QW        = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] QMAX   = QW'(Q - 1);
  localparam logic [7:0] ADDR_BYTE = {ADDR, 1'b0};

  generate
    if (Q < 1) begin : g_q_check
      $error("i2c_byte_tx: CLK_HZ must be at least 4*SCL_HZ");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_DATA,
    S_DACK,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    phase, phase_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    data_q;
  logic          accept, tick, ack_sample, nack;
  logic          scl_n, sda_n, done_n;

  assign accept     = start && (state == S_IDLE);
  assign tick       = (state != S_IDLE) && (qcnt == QMAX);
  assign ack_sample = ((state == S_AACK) || (state == S_DACK)) &&
                      (phase == 2'd3) && (qcnt == '0);
  // With Q=1 the sample cycle is also the slot's last tick, so fold in sda_in.
  assign nack       = ack_err || (ack_sample && sda_in);

  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    phase_n   = phase;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    if (state == S_IDLE) begin
      qcnt_n    = '0;
      phase_n   = 2'd0;
      bit_cnt_n = 3'd0;
      if (accept) state_n = S_START;
    end else if (tick) begin
      qcnt_n  = '0;
      phase_n = phase + 2'd1;
      if (phase == 2'd3) begin
        case (state)
          S_START: state_n = S_ADDR;
          S_ADDR: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_AACK;
          end
          S_AACK:  state_n = nack ? S_STOP : S_DATA;
          S_DATA: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_DACK;
          end
          S_DACK:  state_n = S_STOP;
          S_STOP: begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
          default: state_n = S_IDLE;
        endcase
      end
    end else begin
      qcnt_n = qcnt + 1'b1;
    end
  end

  // Pin levels are decoded from the next phase so the registered outputs line up with it.
  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      S_START: begin
        scl_n = ~phase_n[1];
        sda_n = 1'b0;
      end
      S_ADDR: begin
        scl_n = phase_n[1];
        sda_n = ADDR_BYTE[3'd7 - bit_cnt_n];
      end
      S_DATA: begin
        scl_n = phase_n[1];
        sda_n = data_q[3'd7 - bit_cnt_n];
      end
      S_AACK, S_DACK: begin
        scl_n = phase_n[1];
        sda_n = 1'b1;
      end
      S_STOP: begin
        scl_n = (phase_n != 2'd0);
        sda_n = phase_n[1];
      end
      default: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
      data_q  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl_out <= 1'b1;
      sda_out <= 1'b1;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      busy    <= (state_n != S_IDLE);
      done    <= done_n;
      scl_out <= scl_n;
      sda_out <= sda_n;
      if (accept) begin
        data_q  <= data;
        ack_err <= 1'b0;
      end else if (ack_sample && sda_in) begin
        ack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed bench for i2c_byte_tx at Q=4 with an ACK/NACK slave model
// that decodes the open-drain bus at every SCL rising edge.
module tb_i2c_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       busy, done, ack_err, scl_out, sda_out, sda_in;

  logic       slaveLow = 1'b0;
  logic       ackAddr = 1'b1;
  logic       ackData = 1'b1;
  logic       sdaBus;

  int         nCompared = 0;
  int         nMismatched = 0;

  logic       prevScl = 1'b1;
  logic       prevSda = 1'b1;
  logic       bitArr [0:31];
  int         bitCnt = 0;
  int         startCount = 0;
  int         doneCount = 0;
  logic       stopSeen = 1'b0;

  i2c_byte_tx #(
    .CLK_HZ(1_600_000),
    .SCL_HZ(100_000),
    .ADDR  (7'h27)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .scl_out(scl_out),
    .sda_out(sda_out),
    .sda_in (sda_in)
  );

  always #5 clk = ~clk;

  assign sdaBus = sda_out & ~slaveLow;
  assign sda_in = sdaBus;

  // Bus decoder plus slave: the slave only moves SDA while SCL is low.
  always @(negedge clk) begin
    if (prevScl && scl_out && prevSda && !sdaBus) begin
      startCount++;
      bitCnt   = 0;
      stopSeen = 1'b0;
    end else if (prevScl && scl_out && !prevSda && sdaBus) begin
      stopSeen = 1'b1;
    end else if (!prevScl && scl_out) begin
      if (bitCnt < 32) bitArr[bitCnt] = sdaBus;
      bitCnt++;
    end
    if (done) doneCount++;
    prevScl = scl_out;
    prevSda = sdaBus;
    if (!scl_out)
      slaveLow = (bitCnt == 8 && ackAddr) || (bitCnt == 17 && ackData);
  end

  function automatic logic [7:0] byteAt(input int off);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], bitArr[off + i]};
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raise start for one cycle, then check the cycle after accept.
  task automatic applyStimulus(input string tag, input logic [7:0] b);
    start = 1'b1;
    data  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = 8'h00;
    checkOutput({tag, " busy@accept+1"}, busy, 1);
    checkOutput({tag, " sda@accept+1"}, sda_out, 0);
    checkOutput({tag, " scl@accept+1"}, scl_out, 1);
    checkOutput({tag, " ackerr@accept+1"}, ack_err, 0);
  endtask

  // Returns on the done cycle; elapsed = busy cycles already passed.
  task automatic waitDone(input string tag, input int elapsed, input int expLen);
    int cnt = elapsed;
    while (busy === 1'b1 && cnt < 4000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " busy length"}, cnt, expLen);
    checkOutput({tag, " done pulse"}, done, 1);
    checkOutput({tag, " busy low"}, busy, 0);
  endtask

  // Rising edges include the one inside STOP, so a full frame decodes 19.
  task automatic checkBus(input string tag, input int nEdges, input logic addrAck,
                          input logic [7:0] expData, input logic dataAck);
    checkOutput({tag, " edges"}, bitCnt, nEdges);
    checkOutput({tag, " addr byte"}, byteAt(0), 8'h4E);
    checkOutput({tag, " addr ack"}, bitArr[8], addrAck);
    checkOutput({tag, " stop"}, stopSeen, 1);
    if (nEdges == 19) begin
      checkOutput({tag, " data byte"}, byteAt(9), expData);
      checkOutput({tag, " data ack"}, bitArr[17], dataAck);
    end
  endtask

  initial begin
    int d0, s0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ackerr", ack_err, 0);
    checkOutput("reset scl", scl_out, 1);
    checkOutput("reset sda", sda_out, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic write A5");
    d0 = doneCount;
    applyStimulus("basic", 8'hA5);
    waitDone("basic", 0, 320);
    checkBus("basic", 19, 1'b0, 8'hA5, 1'b0);
    checkOutput("basic ackerr", ack_err, 0);
    @(posedge clk);
    #1;
    checkOutput("basic done width", done, 0);
    checkOutput("basic done count", doneCount - d0, 1);

    $display("[TB] address NACK");
    ackAddr = 1'b0;
    applyStimulus("anack", 8'h11);
    waitDone("anack", 0, 176);
    checkBus("anack", 10, 1'b1, 8'h00, 1'b0);
    checkOutput("anack ackerr", ack_err, 1);
    ackAddr = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] data NACK");
    ackData = 1'b0;
    applyStimulus("dnack", 8'hC3);
    waitDone("dnack", 0, 320);
    checkBus("dnack", 19, 1'b0, 8'hC3, 1'b1);
    checkOutput("dnack ackerr", ack_err, 1);
    ackData = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("dnack ackerr hold", ack_err, 1);

    $display("[TB] back-to-back 5A then 3C");
    applyStimulus("b2b1", 8'h5A);
    waitDone("b2b1", 0, 320);
    checkBus("b2b1", 19, 1'b0, 8'h5A, 1'b0);
    applyStimulus("b2b2", 8'h3C);
    waitDone("b2b2", 0, 320);
    checkBus("b2b2", 19, 1'b0, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] ignored start mid-transfer");
    d0 = doneCount;
    s0 = startCount;
    applyStimulus("ign", 8'hFF);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    data  = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ign", 101, 320);
    checkBus("ign", 19, 1'b0, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("ign done count", doneCount - d0, 1);
    checkOutput("ign start count", startCount - s0, 1);
    checkOutput("ign still idle", busy, 0);

    $display("[TB] reset during DATA bit 3");
    applyStimulus("rstmid", 8'hE7);
    repeat (210) @(posedge clk);
    #1;
    checkOutput("rstmid scl before", scl_out, 0);
    checkOutput("rstmid sda bit3", sda_out, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstmid scl", scl_out, 1);
    checkOutput("rstmid sda", sda_out, 1);
    checkOutput("rstmid busy", busy, 0);
    checkOutput("rstmid done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus("after rst", 8'h81);
    waitDone("after rst", 0, 320);
    checkBus("after rst", 19, 1'b0, 8'h81, 1'b0);
    checkOutput("after rst ackerr", ack_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/i2c_byte_tx.md
# i2c_byte_tx

Write-only I2C master that carries one byte per request to a PCF8574-style port expander. It sits directly downstream of the `hd44780` controller: the controller presents each expander byte (LCD nibble plus RS/RW/E/backlight bits) here, and this block produces the open-drain SCL/SDA drive for the board's I2C pins. Each transaction is START, address byte with write bit, ACK, data byte, ACK, STOP. There is no clock stretching and no reads.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCL_HZ`, 100_000, I2C bit rate.
- `ADDR`, 7'h27, 7-bit expander address.
- `Q` (localparam) = CLK_HZ/(4*SCL_HZ), cycles per quarter-bit. The default is 250. Elaboration must fail if Q < 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe.
- `data`  in  8  byte to send. Sampled only on the accept cycle.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  last transaction saw a NACK.
- `scl_out`  out  1  0 = pull SCL low, 1 = release.
- `sda_out`  out  1  0 = pull SDA low, 1 = release.
- `sda_in`  in  1  SDA pin level, used for ACK sampling.

## Operation
- Reset values: busy=0, done=0, ack_err=0, scl_out=1, sda_out=1. The FSM resets to IDLE and the quarter counter to 0.
- Accept: a request is accepted when `start`=1 and the FSM is in IDLE. On acceptance:
  - `data` is latched.
  - ack_err is cleared.
  - The FSM goes to START.
  - `start` during any other state is ignored; it is not queued.
- Quarter tick: a counter runs 0..Q-1 while not in IDLE. A tick fires when the count reaches Q-1. All phase changes happen on ticks.
- Bit slot, 4 quarters:
  - q0: SCL low, SDA driven to the bit value.
  - q1: SCL low, SDA held.
  - q2: SCL released.
  - q3: SCL released.
  - SDA never changes while SCL is released, except in START and STOP.
- FSM states:
  - IDLE.
  - START: 4 quarters. SDA low with SCL released for 2 quarters, then SCL low for 2 quarters.
  - ADDR: 8 slots, sending {ADDR,1'b0} MSB first.
  - AACK: 1 slot. SDA released.
  - DATA: 8 slots, MSB first.
  - DACK: 1 slot. SDA released.
  - STOP: 4 quarters.
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2–q3: both released.
  - After STOP, the FSM returns to IDLE.
- ACK sampling: `sda_in` is sampled on the first cycle of q3 of AACK and of DACK.
  - 0 = ACK.
  - 1 = NACK: sets ack_err.
  - A NACK in AACK skips DATA and DACK and goes straight to STOP.
- A 3-bit bit counter indexes the shift register and wraps 7→0 between ADDR and DATA.
- Reset mid-transaction: on the next cycle, both lines are released, busy=0, no STOP is generated, and done is not pulsed.

## Timing
- Accept at cycle N:
  - busy=1 from N+1.
  - First SDA low (START) at N+1.
- Normal transaction length: 80·Q cycles (4 + 72 + 4 quarters). With defaults this is 20 000 cycles (200 µs).
- Address-NACK transaction length: 44·Q cycles (4 + 36 + 4 quarters).
- End of transaction:
  - busy falls and done=1 on the same cycle, the first cycle back in IDLE.
  - done lasts exactly 1 cycle.
  - A `start` on that cycle is accepted, so back-to-back transfers have no idle gap beyond that cycle.
- ack_err holds its value until the next accept or reset.
- Outputs are registered; there is no combinational path from `start` or `sda_in` to the SCL/SDA outputs.

## Test plan
- Basic write, Q=4 for simulation, slave model ACKs.
  - Stimulus: `start` with data=8'hA5.
  - Required: the decoded SDA stream at SCL rising edges is 8'h4E, ACK, 8'hA5, ACK.
  - START is SDA falling while SCL=1; STOP is SDA rising while SCL=1.
  - busy lasts exactly 320 cycles, then one done pulse, ack_err=0.
- Address NACK.
  - Stimulus: slave holds SDA released.
  - Required: ack_err=1, no data bits on the bus, STOP present, busy lasts 176 cycles (44·Q with Q=4).
- Data NACK.
  - Stimulus: slave ACKs the address and NACKs the data.
  - Required: full 320-cycle transaction, ack_err=1.
  - The next accepted request clears ack_err to 0 on the cycle after accept.
- Ignored start.
  - Stimulus: pulse `start` with data=8'h00 mid-transfer of 8'hFF.
  - Required: the bus carries only 8'hFF, one done pulse total.
- Back-to-back.
  - Stimulus: assert `start` on the done cycle.
  - Required: the second START begins on the next cycle, and both bytes arrive intact.
- Reset mid-operation.
  - Stimulus: assert `rst` during DATA bit 3.
  - Required: next cycle scl_out=1, sda_out=1, busy=0, done=0.
  - A new request after reset completes normally.
